// File: rtl/int_scheduler_pkg.sv
// Shared constants, FSM encodings and register map for the interrupt scheduler.
package int_scheduler_pkg;
    localparam int NUM_SRC = 16;
    localparam int CODE_W  = 4;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } schedStateT;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_SETPEND = 2'd3;

    function automatic logic [NUM_SRC-1:0] codeToMask(input logic [CODE_W-1:0] code);
        logic [NUM_SRC-1:0] m;
        m       = '0;
        m[code] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/int_scheduler_if.sv
// Peripheral request lines, config register port and core interrupt handshake.
interface int_scheduler_if;
    import int_scheduler_pkg::*;

    logic [NUM_SRC-1:0] i_srcIrq;
    logic [1:0]         i_cfgAddr;
    logic [DATA_W-1:0]  i_cfgWrData;
    logic               i_cfgWr;
    logic [DATA_W-1:0]  o_cfgRdData;
    logic [CODE_W-1:0]  o_intCode;
    logic               o_intEn;
    logic               i_intAck;
    logic               i_intDone;

    modport master (
        output i_srcIrq, i_cfgAddr, i_cfgWrData, i_cfgWr, i_intAck, i_intDone,
        input  o_cfgRdData, o_intCode, o_intEn
    );

    modport slave (
        input  i_srcIrq, i_cfgAddr, i_cfgWrData, i_cfgWr, i_intAck, i_intDone,
        output o_cfgRdData, o_intCode, o_intEn
    );
endinterface

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder: bit 0 is the highest priority source.
module int_prio_enc
    import int_scheduler_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [CODE_W-1:0]  code
);
    always_comb begin
        valid = |req;
        code  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) code = CODE_W'(i);
        end
    end
endmodule

// File: rtl/int_scheduler.sv
// Interrupt scheduler: edge capture, pending/enable registers and a single
// in-service request/ack/RTI tracker driving the core interrupt inputs.
module int_scheduler
    import int_scheduler_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rstn,
    int_scheduler_if.slave bus
);
    logic [NUM_SRC-1:0] srcQ, pending, enable;
    logic [NUM_SRC-1:0] edgeDet, setVec, clrVec, pendNext, enNext;
    logic [NUM_SRC-1:0] cand, candNext;
    logic               wrEnable, wrPending, wrSetPend, ackHit;
    logic               selValid;
    logic [CODE_W-1:0]  selCode, codeQ;
    logic               intEnQ;
    schedStateT         state;

    assign wrEnable  = bus.i_cfgWr && (bus.i_cfgAddr == ADDR_ENABLE);
    assign wrPending = bus.i_cfgWr && (bus.i_cfgAddr == ADDR_PENDING);
    assign wrSetPend = bus.i_cfgWr && (bus.i_cfgAddr == ADDR_SETPEND);
    assign ackHit    = (state == ST_REQ) && bus.i_intAck;

    assign edgeDet  = bus.i_srcIrq & ~srcQ;
    assign setVec   = edgeDet | (wrSetPend ? bus.i_cfgWrData : '0);
    assign clrVec   = (wrPending ? bus.i_cfgWrData : '0) | (ackHit ? codeToMask(codeQ) : '0);
    // Set is OR'd in last so it wins over any same-cycle clear.
    assign pendNext = setVec | (pending & ~clrVec);
    assign enNext   = wrEnable ? bus.i_cfgWrData : enable;

    assign cand     = pending & enable;
    // Withdrawal looks at next-cycle values so a W1C or disable drops REQ at once.
    assign candNext = pendNext & enNext;

    int_prio_enc uPrioEnc (
        .req   (cand),
        .valid (selValid),
        .code  (selCode)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            srcQ    <= '0;
            pending <= '0;
            enable  <= '0;
        end else begin
            srcQ    <= bus.i_srcIrq;
            pending <= pendNext;
            enable  <= enNext;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= ST_IDLE;
            codeQ  <= '0;
            intEnQ <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (selValid) begin
                        state  <= ST_REQ;
                        codeQ  <= selCode;
                        intEnQ <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.i_intAck) begin
                        state  <= ST_ACTIVE;
                        intEnQ <= 1'b0;
                    end else if (!candNext[codeQ]) begin
                        state  <= ST_IDLE;
                        intEnQ <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (bus.i_intDone) state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    intEnQ <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_intEn   = intEnQ;
    assign bus.o_intCode = codeQ;

    always_comb begin
        bus.o_cfgRdData = '0;
        case (bus.i_cfgAddr)
            ADDR_ENABLE:  bus.o_cfgRdData = enable;
            ADDR_PENDING: bus.o_cfgRdData = pending;
            ADDR_STATUS:  bus.o_cfgRdData = {10'b0, 2'(state), codeQ};
            default:      bus.o_cfgRdData = '0;
        endcase
    end
endmodule
